// File: rtl/mem_port_pkg.sv
// Shared types and defaults for the memory port controller and its arbiter.
package mem_port_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  localparam int MP_ADDR_W = 11;
  localparam int MP_DATA_W = 32;
  localparam int MP_DEPTH  = 64;

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-port grant: a lone requester wins; on conflict the port not granted last wins.
// Combinational grant, last-grant register updates only when the controller accepts a grant.
module mem_rr_arbiter
  import mem_port_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic f_req,
  input  logic d_req,
  input  logic gnt_en,
  output logic gnt_port
);

  logic last_port;

  always_comb begin
    gnt_port = PORT_DATA;
    if (f_req && !d_req) begin
      gnt_port = PORT_FETCH;
    end else if (f_req && d_req && (last_port == PORT_DATA)) begin
      gnt_port = PORT_FETCH;
    end
  end

  // Reset to fetch so the first conflict goes to the data port.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_port <= PORT_FETCH;
    end else if (gnt_en) begin
      last_port <= gnt_port;
    end
  end

endmodule

// File: rtl/mem_port_ctrl.sv
// Fetch/data front end for a negedge single-port RAM; in-range ack 2 cycles after the req is sampled, range error 1 cycle.
// No backpressure beyond req/ack: a master holds req and its fields until its ack pulse.
module mem_port_ctrl
  import mem_port_pkg::*;
#(
  parameter int ADDR_W = MP_ADDR_W,
  parameter int DATA_W = MP_DATA_W,
  parameter int DEPTH  = MP_DEPTH
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic              f_err,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_t            state;
  logic              port_q;
  logic              gnt_en;
  logic              gnt_port;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic              sel_err;
  logic [DATA_W-1:0] sel_wdata;

  assign gnt_en = (state == IDLE) && (f_req || d_req);

  mem_rr_arbiter u_arb (
    .clock    (clock),
    .reset_n  (reset_n),
    .f_req    (f_req),
    .d_req    (d_req),
    .gnt_en   (gnt_en),
    .gnt_port (gnt_port)
  );

  // Fetch is read-only, so its we is forced low regardless of d_we.
  always_comb begin
    sel_addr  = (gnt_port == PORT_DATA) ? d_addr : f_addr;
    sel_we    = (gnt_port == PORT_DATA) && d_we;
    sel_wdata = sel_we ? d_wdata : '0;
    sel_err   = (sel_addr >= ADDR_W'(DEPTH));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      port_q    <= PORT_FETCH;
      f_ack     <= 1'b0;
      f_err     <= 1'b0;
      f_rdata   <= '0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= '0;
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_en) begin
            port_q <= gnt_port;
            if (sel_err) begin
              // Out of range: answer straight away, RAM never selected.
              state <= RESP;
              if (gnt_port == PORT_DATA) begin
                d_ack <= 1'b1;
                d_err <= 1'b1;
              end else begin
                f_ack <= 1'b1;
                f_err <= 1'b1;
              end
            end else begin
              state     <= ACCESS;
              ram_cs    <= 1'b1;
              ram_we    <= sel_we;
              ram_addr  <= sel_addr;
              ram_wdata <= sel_wdata;
            end
          end
        end
        ACCESS: begin
          // RAM drove its output on the mid-cycle negedge; cs is still high here.
          if (!ram_we) begin
            if (port_q == PORT_DATA) begin
              d_rdata <= ram_rdata;
            end else begin
              f_rdata <= ram_rdata;
            end
          end
          if (port_q == PORT_DATA) begin
            d_ack <= 1'b1;
          end else begin
            f_ack <= 1'b1;
          end
          ram_cs    <= 1'b0;
          ram_we    <= 1'b0;
          ram_wdata <= '0;
          state     <= RESP;
        end
        RESP: begin
          f_ack <= 1'b0;
          f_err <= 1'b0;
          d_ack <= 1'b0;
          d_err <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl with a negedge RAM model behind it.
module tb_mem_port_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        f_req;
  logic [10:0] f_addr;
  logic        f_ack, f_err;
  logic [31:0] f_rdata;
  logic        d_req, d_we;
  logic [10:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack, d_err;
  logic [31:0] d_rdata;
  logic        ram_cs, ram_we;
  logic [10:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  mem_port_ctrl dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_ack     (f_ack),
    .f_err     (f_err),
    .f_rdata   (f_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_err     (d_err),
    .d_rdata   (d_rdata),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Negedge RAM; a junk pattern stands in for the floating bus when deselected.
  logic [31:0] mem [0:63];
  logic [31:0] ram_q;
  always @(negedge clock) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_addr[5:0]] <= ram_wdata;
      else        ram_q <= mem[ram_addr[5:0]];
    end
  end
  assign ram_rdata = ram_cs ? ram_q : 32'hBAD0_BAD0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ":acks"}, {30'd0, f_ack, d_ack}, 32'd0);
    chk({tag, ":errs"}, {30'd0, f_err, d_err}, 32'd0);
    chk({tag, ":f_rdata"}, f_rdata, 32'd0);
    chk({tag, ":d_rdata"}, d_rdata, 32'd0);
    chk({tag, ":ram_ctl"}, {30'd0, ram_cs, ram_we}, 32'd0);
    chk({tag, ":ram_addr"}, {21'd0, ram_addr}, 32'd0);
    chk({tag, ":ram_wdata"}, ram_wdata, 32'd0);
  endtask

  // One complete transaction on one port, checked cycle by cycle.
  task automatic xact(input bit is_d, input bit we, input logic [10:0] addr,
                      input logic [31:0] wd, input bit exp_err,
                      input logic [31:0] exp_rd, input string tag);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
    end else begin
      f_req = 1'b1; f_addr = addr;
    end
    @(posedge clock); #1;
    if (!exp_err) begin
      chk({tag, ":cs"}, {31'd0, ram_cs}, 32'd1);
      chk({tag, ":we"}, {31'd0, ram_we}, {31'd0, we});
      chk({tag, ":addr"}, {21'd0, ram_addr}, {21'd0, addr});
      chk({tag, ":ack_early"}, {30'd0, f_ack, d_ack}, 32'd0);
      @(posedge clock); #1;
    end else begin
      chk({tag, ":cs_err"}, {31'd0, ram_cs}, 32'd0);
    end
    chk({tag, ":ack"}, {30'd0, f_ack, d_ack}, is_d ? 32'd1 : 32'd2);
    chk({tag, ":err"}, {31'd0, is_d ? d_err : f_err}, {31'd0, exp_err});
    chk({tag, ":cs_off"}, {31'd0, ram_cs}, 32'd0);
    chk({tag, ":rdata"}, is_d ? d_rdata : f_rdata, exp_rd);
    d_req = 1'b0;
    f_req = 1'b0;
    @(posedge clock); #1;
    chk({tag, ":ack_clr"}, {30'd0, f_ack, d_ack}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    f_req = 1'b0; f_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    #2;
    chk_reset_state("reset");
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    xact(1'b1, 1'b1, 11'd5, 32'hDEADBEEF, 1'b0, 32'h0, "d_wr5");
    xact(1'b1, 1'b0, 11'd5, 32'h0, 1'b0, 32'hDEADBEEF, "d_rd5");
    xact(1'b1, 1'b1, 11'd7, 32'h12345678, 1'b0, 32'hDEADBEEF, "d_wr7");
    xact(1'b0, 1'b0, 11'd7, 32'h0, 1'b0, 32'h12345678, "f_rd7");
    xact(1'b1, 1'b0, 11'd64, 32'h0, 1'b1, 32'hDEADBEEF, "d_rd64");
    xact(1'b1, 1'b0, 11'h7FF, 32'h0, 1'b1, 32'hDEADBEEF, "d_rd7ff");
    xact(1'b0, 1'b0, 11'd64, 32'h0, 1'b1, 32'h12345678, "f_rd64");
    xact(1'b1, 1'b1, 11'd3, 32'h11111111, 1'b0, 32'hDEADBEEF, "d_wr3_old");

    // Conflict: both masters hold req, grants must alternate starting with data.
    reset_n = 1'b0;
    #1;
    chk_reset_state("rr_reset");
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    f_req = 1'b1; f_addr = 11'd7;
    d_req = 1'b1; d_we = 1'b0; d_addr = 11'd5;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
      chk($sformatf("rr%0d:addr", k), {21'd0, ram_addr}, (k % 2 == 0) ? 32'd5 : 32'd7);
      @(posedge clock); #1;
      chk($sformatf("rr%0d:ack", k), {30'd0, f_ack, d_ack}, (k % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("rr%0d:rdata", k), (k % 2 == 0) ? d_rdata : f_rdata,
          (k % 2 == 0) ? 32'hDEADBEEF : 32'h12345678);
      if (k == 3) begin
        f_req = 1'b0;
        d_req = 1'b0;
      end
      @(posedge clock); #1;
      chk($sformatf("rr%0d:ack_clr", k), {30'd0, f_ack, d_ack}, 32'd0);
    end

    // Reset during ACCESS before the RAM's negedge: write must be lost.
    d_req = 1'b1; d_we = 1'b1; d_addr = 11'd3; d_wdata = 32'hA5A5A5A5;
    @(posedge clock); #1;
    chk("rst_pre:cs", {31'd0, ram_cs}, 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk_reset_state("rst_pre");
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("rst_pre:no_ack", {30'd0, f_ack, d_ack}, 32'd0);
    xact(1'b1, 1'b0, 11'd3, 32'h0, 1'b0, 32'h11111111, "rst_pre_rd3");

    // Reset during ACCESS after the negedge: write already committed.
    d_req = 1'b1; d_we = 1'b1; d_addr = 11'd3; d_wdata = 32'hA5A5A5A5;
    @(posedge clock); #1;
    chk("rst_post:cs", {31'd0, ram_cs}, 32'd1);
    @(negedge clock); #1;
    reset_n = 1'b0;
    #1;
    chk_reset_state("rst_post");
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("rst_post:no_ack", {30'd0, f_ack, d_ack}, 32'd0);
    xact(1'b1, 1'b0, 11'd3, 32'h0, 1'b0, 32'hA5A5A5A5, "rst_post_rd3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
